// File: rtl/mem_arbiter.sv
// Memory-bus arbiter: a store buffer plus load and instruction-fetch requesters sharing one bus.
// Grants are combinational from registered state; a request is accepted when memory returns a nonzero tag.
module mem_arbiter #(
   parameter int SB_DEPTH     = 4,
   parameter int STARVE_LIMIT = 8,
   parameter int XLEN         = 32
) (
   input  logic                      clock,
   input  logic                      reset,
   input  logic [1:0]                st_command,
   input  logic [1:0]                st_size,
   input  logic [XLEN-1:0]           st_addr,
   input  logic [XLEN-1:0]           st_data,
   input  logic                      ld_req,
   input  logic [XLEN-1:0]           ld_addr,
   input  logic [1:0]                ld_size,
   input  logic                      if_req,
   input  logic [XLEN-1:0]           if_addr,
   input  logic                      drain_req,
   input  logic [3:0]                mem2proc_response,
   output logic [1:0]                proc2mem_command,
   output logic [XLEN-1:0]           proc2mem_addr,
   output logic [63:0]               proc2mem_data,
   output logic [1:0]                proc2mem_size,
   output logic [3:0]                ld_resp,
   output logic [3:0]                if_resp,
   output logic                      sb_full,
   output logic                      sb_empty,
   output logic [$clog2(SB_DEPTH):0] sb_count,
   output logic                      sb_overflow
);

   localparam logic [1:0] BUS_NONE  = 2'd0;
   localparam logic [1:0] BUS_LOAD  = 2'd1;
   localparam logic [1:0] BUS_STORE = 2'd2;
   localparam logic [1:0] SIZE_DOUBLE = 2'd3;

   localparam int PW = $clog2(SB_DEPTH);
   localparam int SW = $clog2(STARVE_LIMIT + 1);

   typedef enum logic {NORMAL, DRAIN} mode_t;
   typedef enum logic [1:0] {G_NONE, G_STORE, G_LOAD, G_FETCH} grant_t;

   logic [XLEN-1:0] sb_addr_mem [SB_DEPTH];
   logic [XLEN-1:0] sb_data_mem [SB_DEPTH];
   logic [1:0]      sb_size_mem [SB_DEPTH];

   logic [PW-1:0]   head_reg, tail_reg;
   logic [PW:0]     count_reg, count_next;
   logic            overflow_reg;
   logic [SW-1:0]   starve_reg, starve_next;
   mode_t           mode_reg, mode_next;
   grant_t          grant;

   logic            enq, deq, accept, promoted, sb_nonempty, ld_conflict;
   logic [SB_DEPTH-1:0] conflict_vec;

   assign sb_full     = (count_reg == (PW+1)'(SB_DEPTH));
   assign sb_empty    = (count_reg == '0);
   assign sb_count    = count_reg;
   assign sb_overflow = overflow_reg;
   assign sb_nonempty = !sb_empty;

   assign enq      = (st_command == BUS_STORE) && !sb_full;
   assign accept   = (grant != G_NONE) && (mem2proc_response != 4'd0);
   assign deq      = accept && (grant == G_STORE);
   assign promoted = if_req && (starve_reg == SW'(STARVE_LIMIT));

   // An entry is live when its distance from the head is below the registered count.
   generate
      for (genvar gi = 0; gi < SB_DEPTH; gi++) begin : g_conflict
         logic [PW-1:0] offset;
         assign offset = PW'(gi) - head_reg;
         assign conflict_vec[gi] = ({1'b0, offset} < count_reg) &&
                                   (sb_addr_mem[gi][XLEN-1:3] == ld_addr[XLEN-1:3]);
      end
   endgenerate

   assign ld_conflict = ld_req && (|conflict_vec);

   always_comb begin
      grant = G_NONE;
      if (mode_reg == DRAIN && sb_nonempty)
         grant = G_STORE;
      else if (promoted)
         grant = G_FETCH;
      else if (ld_conflict)
         grant = G_STORE;
      else if (ld_req)
         grant = G_LOAD;
      else if (if_req)
         grant = G_FETCH;
      else if (sb_nonempty)
         grant = G_STORE;
   end

   always_comb begin
      proc2mem_command = BUS_NONE;
      proc2mem_addr    = '0;
      proc2mem_data    = '0;
      proc2mem_size    = '0;
      ld_resp          = 4'd0;
      if_resp          = 4'd0;
      case (grant)
         G_STORE: begin
            proc2mem_command          = BUS_STORE;
            proc2mem_addr             = sb_addr_mem[head_reg];
            proc2mem_data[XLEN-1:0]   = sb_data_mem[head_reg];
            proc2mem_size             = sb_size_mem[head_reg];
         end
         G_LOAD: begin
            proc2mem_command = BUS_LOAD;
            proc2mem_addr    = ld_addr;
            proc2mem_size    = ld_size;
            if (accept) ld_resp = mem2proc_response;
         end
         G_FETCH: begin
            proc2mem_command = BUS_LOAD;
            proc2mem_addr    = if_addr;
            proc2mem_size    = SIZE_DOUBLE;
            if (accept) if_resp = mem2proc_response;
         end
         default: ;
      endcase
   end

   always_comb begin
      count_next = count_reg;
      case ({enq, deq})
         2'b10:   count_next = count_reg + 1'b1;
         2'b01:   count_next = count_reg - 1'b1;
         default: count_next = count_reg;
      endcase
   end

   always_comb begin
      mode_next = mode_reg;
      case (mode_reg)
         NORMAL: if (count_next >= (PW+1)'(SB_DEPTH-1) || drain_req) mode_next = DRAIN;
         DRAIN:  if (count_reg == '0 && !drain_req) mode_next = NORMAL;
         default: mode_next = NORMAL;
      endcase
   end

   always_comb begin
      starve_next = starve_reg;
      if (!if_req || (accept && grant == G_FETCH))
         starve_next = '0;
      else if (starve_reg != SW'(STARVE_LIMIT))
         starve_next = starve_reg + 1'b1;
   end

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         head_reg     <= '0;
         tail_reg     <= '0;
         count_reg    <= '0;
         overflow_reg <= 1'b0;
         starve_reg   <= '0;
         mode_reg     <= NORMAL;
      end else begin
         if (enq) tail_reg <= tail_reg + 1'b1;
         if (deq) head_reg <= head_reg + 1'b1;
         count_reg  <= count_next;
         starve_reg <= starve_next;
         mode_reg   <= mode_next;
         if (st_command == BUS_STORE && sb_full) overflow_reg <= 1'b1;
      end
   end

   // Storage carries no reset; liveness comes from the pointers and count.
   always_ff @(posedge clock) begin
      if (enq) begin
         sb_addr_mem[tail_reg] <= st_addr;
         sb_data_mem[tail_reg] <= st_data;
         sb_size_mem[tail_reg] <= st_size;
      end
   end

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter: FIFO order, load conflict, fetch starvation, drain mode, overflow and reset.
module tb_mem_arbiter;
   localparam int XLEN = 32;
   localparam logic [1:0] NONE = 2'd0, LOAD = 2'd1, STORE = 2'd2;
   localparam logic [1:0] WORD = 2'd2, DOUBLE = 2'd3;

   logic clock = 1'b0, reset;
   logic [1:0] st_command, st_size, ld_size;
   logic [XLEN-1:0] st_addr, st_data, ld_addr, if_addr;
   logic ld_req, if_req, drain_req;
   logic [3:0] mem2proc_response;
   logic [1:0] proc2mem_command, proc2mem_size;
   logic [XLEN-1:0] proc2mem_addr;
   logic [63:0] proc2mem_data;
   logic [3:0] ld_resp, if_resp;
   logic sb_full, sb_empty, sb_overflow;
   logic [2:0] sb_count;

   int checks = 0;
   int errors = 0;

   always #5 clock = ~clock;

   mem_arbiter dut (
      .clock(clock), .reset(reset),
      .st_command(st_command), .st_size(st_size), .st_addr(st_addr), .st_data(st_data),
      .ld_req(ld_req), .ld_addr(ld_addr), .ld_size(ld_size),
      .if_req(if_req), .if_addr(if_addr), .drain_req(drain_req),
      .mem2proc_response(mem2proc_response),
      .proc2mem_command(proc2mem_command), .proc2mem_addr(proc2mem_addr),
      .proc2mem_data(proc2mem_data), .proc2mem_size(proc2mem_size),
      .ld_resp(ld_resp), .if_resp(if_resp),
      .sb_full(sb_full), .sb_empty(sb_empty), .sb_count(sb_count), .sb_overflow(sb_overflow)
   );

   task automatic idle();
      st_command = NONE; st_size = WORD; st_addr = '0; st_data = '0;
      ld_req = 1'b0; ld_addr = '0; ld_size = WORD;
      if_req = 1'b0; if_addr = '0; drain_req = 1'b0; mem2proc_response = 4'd0;
   endtask

   task automatic next_cycle();
      $display("t=%0t cmd=%0d addr=%h data=%h size=%0d resp=%0d ld_resp=%0d if_resp=%0d count=%0d",
               $time, proc2mem_command, proc2mem_addr, proc2mem_data, proc2mem_size,
               mem2proc_response, ld_resp, if_resp, sb_count);
      @(posedge clock); #1;
   endtask

   task automatic store(input logic [XLEN-1:0] a, input logic [XLEN-1:0] d);
      st_command = STORE; st_addr = a; st_data = d; st_size = WORD;
   endtask

   task automatic do_reset();
      idle(); reset = 1'b0;
      @(posedge clock); #1;
      reset = 1'b1;
   endtask

   task automatic test_reset();
      idle(); reset = 1'b0;
      @(negedge clock);
      checks++; if (sb_empty !== 1'b1) begin errors++; $display("FAIL reset_empty got %b want 1", sb_empty); end
      checks++; if (sb_full !== 1'b0) begin errors++; $display("FAIL reset_full got %b want 0", sb_full); end
      checks++; if (sb_count !== 3'd0) begin errors++; $display("FAIL reset_count got %0d want 0", sb_count); end
      checks++; if (proc2mem_command !== NONE) begin errors++; $display("FAIL reset_cmd got %0d want 0", proc2mem_command); end
      checks++; if (ld_resp !== 4'd0 || if_resp !== 4'd0) begin errors++; $display("FAIL reset_resp got %0d/%0d want 0/0", ld_resp, if_resp); end
      checks++; if (sb_overflow !== 1'b0) begin errors++; $display("FAIL reset_ovf got %b want 0", sb_overflow); end
      @(posedge clock); #1;
      reset = 1'b1;
   endtask

   task automatic test_fifo_order();
      idle(); mem2proc_response = 4'd1;
      store(32'h100, 32'hAAAA_0001);
      @(negedge clock);
      checks++; if (proc2mem_command !== NONE) begin errors++; $display("FAIL fifo_first_idle got %0d want 0", proc2mem_command); end
      next_cycle();
      store(32'h108, 32'hAAAA_0002);
      @(negedge clock);
      checks++; if (proc2mem_command !== STORE || proc2mem_addr !== 32'h100 || proc2mem_data !== 64'hAAAA_0001 || proc2mem_size !== WORD)
         begin errors++; $display("FAIL fifo_st0 got %0d/%h/%h/%0d want 2/100/aaaa0001/2", proc2mem_command, proc2mem_addr, proc2mem_data, proc2mem_size); end
      next_cycle();
      st_command = NONE;
      @(negedge clock);
      checks++; if (sb_count !== 3'd1) begin errors++; $display("FAIL fifo_count_mid got %0d want 1", sb_count); end
      checks++; if (proc2mem_command !== STORE || proc2mem_addr !== 32'h108 || proc2mem_data !== 64'hAAAA_0002)
         begin errors++; $display("FAIL fifo_st1 got %0d/%h/%h want 2/108/aaaa0002", proc2mem_command, proc2mem_addr, proc2mem_data); end
      next_cycle();
      @(negedge clock);
      checks++; if (sb_count !== 3'd0 || sb_empty !== 1'b1) begin errors++; $display("FAIL fifo_count_end got %0d/%b want 0/1", sb_count, sb_empty); end
      checks++; if (proc2mem_command !== NONE) begin errors++; $display("FAIL fifo_end_idle got %0d want 0", proc2mem_command); end
      next_cycle();
   endtask

   task automatic test_conflict();
      idle();
      store(32'h200, 32'h0000_0055);
      next_cycle();
      st_command = NONE; ld_req = 1'b1; ld_addr = 32'h204; ld_size = WORD; mem2proc_response = 4'd0;
      @(negedge clock);
      checks++; if (proc2mem_command !== STORE || proc2mem_addr !== 32'h200 || ld_resp !== 4'd0)
         begin errors++; $display("FAIL conflict_rej got %0d/%h/%0d want 2/200/0", proc2mem_command, proc2mem_addr, ld_resp); end
      next_cycle();
      mem2proc_response = 4'd3;
      @(negedge clock);
      checks++; if (sb_count !== 3'd1) begin errors++; $display("FAIL conflict_rej_count got %0d want 1", sb_count); end
      checks++; if (proc2mem_command !== STORE || proc2mem_addr !== 32'h200 || ld_resp !== 4'd0)
         begin errors++; $display("FAIL conflict_store got %0d/%h/%0d want 2/200/0", proc2mem_command, proc2mem_addr, ld_resp); end
      next_cycle();
      @(negedge clock);
      checks++; if (proc2mem_command !== LOAD || proc2mem_addr !== 32'h204 || proc2mem_size !== WORD || ld_resp !== 4'd3 || if_resp !== 4'd0)
         begin errors++; $display("FAIL conflict_load got %0d/%h/%0d/%0d/%0d want 1/204/2/3/0", proc2mem_command, proc2mem_addr, proc2mem_size, ld_resp, if_resp); end
      next_cycle();
      idle();
   endtask

   task automatic test_starve();
      idle();
      ld_req = 1'b1; ld_addr = 32'h400; if_req = 1'b1; if_addr = 32'h1000; mem2proc_response = 4'd5;
      for (int k = 0; k < 10; k++) begin
         @(negedge clock);
         if (k == 8) begin
            checks++; if (proc2mem_command !== LOAD || proc2mem_addr !== 32'h1000 || proc2mem_size !== DOUBLE || if_resp !== 4'd5 || ld_resp !== 4'd0)
               begin errors++; $display("FAIL starve_fetch cyc %0d got %0d/%h/%0d/%0d/%0d want 1/1000/3/5/0", k, proc2mem_command, proc2mem_addr, proc2mem_size, if_resp, ld_resp); end
         end else begin
            checks++; if (proc2mem_command !== LOAD || proc2mem_addr !== 32'h400 || ld_resp !== 4'd5 || if_resp !== 4'd0)
               begin errors++; $display("FAIL starve_load cyc %0d got %0d/%h/%0d/%0d want 1/400/5/0", k, proc2mem_command, proc2mem_addr, ld_resp, if_resp); end
         end
         next_cycle();
      end
      idle();
   endtask

   task automatic test_drain();
      do_reset();
      store(32'h500, 32'h0000_5001);
      next_cycle();
      store(32'h508, 32'h0000_5081);
      next_cycle();
      st_command = NONE; drain_req = 1'b1;
      ld_req = 1'b1; ld_addr = 32'h900; if_req = 1'b1; if_addr = 32'h2000;
      @(negedge clock);
      checks++; if (sb_count !== 3'd2 || proc2mem_command !== LOAD || proc2mem_addr !== 32'h900)
         begin errors++; $display("FAIL drain_pre got %0d/%0d/%h want 2/1/900", sb_count, proc2mem_command, proc2mem_addr); end
      next_cycle();
      mem2proc_response = 4'd7;
      @(negedge clock);
      checks++; if (proc2mem_command !== STORE || proc2mem_addr !== 32'h500 || ld_resp !== 4'd0 || if_resp !== 4'd0)
         begin errors++; $display("FAIL drain_st0 got %0d/%h/%0d/%0d want 2/500/0/0", proc2mem_command, proc2mem_addr, ld_resp, if_resp); end
      next_cycle();
      @(negedge clock);
      checks++; if (proc2mem_command !== STORE || proc2mem_addr !== 32'h508 || proc2mem_data !== 64'h5081)
         begin errors++; $display("FAIL drain_st1 got %0d/%h/%h want 2/508/5081", proc2mem_command, proc2mem_addr, proc2mem_data); end
      next_cycle();
      @(negedge clock);
      checks++; if (sb_empty !== 1'b1 || proc2mem_command !== LOAD || ld_resp !== 4'd7)
         begin errors++; $display("FAIL drain_empty_load got %b/%0d/%0d want 1/1/7", sb_empty, proc2mem_command, ld_resp); end
      next_cycle();
      drain_req = 1'b0; ld_req = 1'b0;
      @(negedge clock);
      checks++; if (proc2mem_command !== LOAD || proc2mem_addr !== 32'h2000 || if_resp !== 4'd7)
         begin errors++; $display("FAIL drain_fetch got %0d/%h/%0d want 1/2000/7", proc2mem_command, proc2mem_addr, if_resp); end
      next_cycle();
      if_req = 1'b0; mem2proc_response = 4'd0;
      store(32'h600, 32'h0000_6001);
      next_cycle();
      st_command = NONE; ld_req = 1'b1; ld_addr = 32'hA00;
      @(negedge clock);
      checks++; if (proc2mem_command !== LOAD || proc2mem_addr !== 32'hA00)
         begin errors++; $display("FAIL drain_back_normal got %0d/%h want 1/a00", proc2mem_command, proc2mem_addr); end
      next_cycle();
      idle();
   endtask

   task automatic test_overflow_reset();
      do_reset();
      ld_req = 1'b1; ld_addr = 32'h800; mem2proc_response = 4'd0;
      for (int k = 0; k < 3; k++) begin
         store(32'h300 + 32'(k * 8), 32'h3000 + 32'(k));
         @(negedge clock);
         checks++; if (proc2mem_command !== LOAD || proc2mem_addr !== 32'h800)
            begin errors++; $display("FAIL ovf_normal cyc %0d got %0d/%h want 1/800", k, proc2mem_command, proc2mem_addr); end
         next_cycle();
      end
      store(32'h318, 32'h3003);
      @(negedge clock);
      checks++; if (sb_count !== 3'd3 || proc2mem_command !== STORE || proc2mem_addr !== 32'h300)
         begin errors++; $display("FAIL ovf_drain_at3 got %0d/%0d/%h want 3/2/300", sb_count, proc2mem_command, proc2mem_addr); end
      next_cycle();
      store(32'h320, 32'h3004);
      @(negedge clock);
      checks++; if (sb_full !== 1'b1 || sb_count !== 3'd4 || sb_overflow !== 1'b0)
         begin errors++; $display("FAIL ovf_full got %b/%0d/%b want 1/4/0", sb_full, sb_count, sb_overflow); end
      next_cycle();
      idle(); mem2proc_response = 4'd1;
      @(negedge clock);
      checks++; if (sb_overflow !== 1'b1 || sb_count !== 3'd4) begin errors++; $display("FAIL ovf_sticky got %b/%0d want 1/4", sb_overflow, sb_count); end
      checks++; if (proc2mem_command !== STORE || proc2mem_addr !== 32'h300 || proc2mem_data !== 64'h3000)
         begin errors++; $display("FAIL ovf_head got %0d/%h/%h want 2/300/3000", proc2mem_command, proc2mem_addr, proc2mem_data); end
      next_cycle();
      @(negedge clock);
      checks++; if (sb_count !== 3'd3 || proc2mem_addr !== 32'h308 || proc2mem_data !== 64'h3001)
         begin errors++; $display("FAIL rst_pre got %0d/%h/%h want 3/308/3001", sb_count, proc2mem_addr, proc2mem_data); end
      #1 reset = 1'b0;
      #1;
      checks++; if (sb_count !== 3'd0 || sb_empty !== 1'b1 || sb_full !== 1'b0 || sb_overflow !== 1'b0)
         begin errors++; $display("FAIL rst_async got %0d/%b/%b/%b want 0/1/0/0", sb_count, sb_empty, sb_full, sb_overflow); end
      checks++; if (proc2mem_command !== NONE) begin errors++; $display("FAIL rst_async_cmd got %0d want 0", proc2mem_command); end
      @(posedge clock); #1;
      reset = 1'b1;
      for (int k = 0; k < 4; k++) begin
         @(negedge clock);
         checks++; if (proc2mem_command !== NONE || sb_empty !== 1'b1)
            begin errors++; $display("FAIL rst_after cyc %0d got %0d/%b want 0/1", k, proc2mem_command, sb_empty); end
         next_cycle();
      end
      idle();
   endtask

   initial begin
      idle();
      test_reset();
      test_fifo_order();
      test_conflict();
      test_starve();
      test_drain();
      test_overflow_reset();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
